// File: rtl/c432_seq_pkg.sv
// Shared types and constants for the c432 fault-emulation campaign sequencer.
// lfsr_next() is the reference step of the stimulus generator.
package c432_seq_pkg;
    localparam int IN_W       = 36;
    localparam int OUT_W      = 7;
    localparam int CNT_W      = 32;
    localparam int LFSR_TAP_A = 36;
    localparam int LFSR_TAP_B = 25;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        APPLY,
        COMPARE,
        DONE
    } seq_state_e;

    function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] s);
        return {s[IN_W-2:0], s[LFSR_TAP_A-1] ^ s[LFSR_TAP_B-1]};
    endfunction
endpackage

// File: rtl/c432_seq_lfsr.sv
// Fibonacci LFSR that shifts left, with feedback into bit 0.
// A zero seed is replaced by 1 so the register never locks up.
module c432_seq_lfsr #(
    parameter int W     = 36,
    parameter int TAP_A = 36,
    parameter int TAP_B = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] seed_i,
    output logic [W-1:0] value_o
);
    logic [W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? W'(1) : seed_i;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[W-2:0], lfsr_q[TAP_A-1] ^ lfsr_q[TAP_B-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= '0;
        else        lfsr_q <= lfsr_d;
    end

    assign value_o = lfsr_q;
endmodule

// File: rtl/c432_campaign_sequencer.sv
// Runs one fault-emulation campaign over a golden/faulty c432 pair: LFSR stimulus,
// settle wait, response compare, vector/mismatch counting and first-failure capture.
module c432_campaign_sequencer
    import c432_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] num_vectors_i,
    input  logic [IN_W-1:0]  seed_i,
    output logic [IN_W-1:0]  dut_in_o,
    input  logic [OUT_W-1:0] golden_out_i,
    input  logic [OUT_W-1:0] faulty_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] vec_cnt_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic             err_pulse_o,
    output logic [IN_W-1:0]  first_fail_vec_o,
    output logic             first_fail_valid_o
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
    logic [IN_W-1:0]  seed_q, seed_d;
    logic [IN_W-1:0]  ff_vec_q, ff_vec_d;
    logic             ff_valid_q, ff_valid_d;
    logic             err_q, err_d;
    logic             lfsr_load, lfsr_step;
    logic [IN_W-1:0]  lfsr_val;

    c432_seq_lfsr #(
        .W     (IN_W),
        .TAP_A (LFSR_TAP_A),
        .TAP_B (LFSR_TAP_B)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .seed_i  (seed_q),
        .value_o (lfsr_val)
    );

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        num_d      = num_q;
        seed_d     = seed_q;
        vec_cnt_d  = vec_cnt_q;
        mm_cnt_d   = mm_cnt_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        err_d      = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;

        // Abort suppresses every update of the cycle, so partial results stay as they were.
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        num_d   = num_vectors_i;
                        seed_d  = seed_i;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    lfsr_load  = 1'b1;
                    vec_cnt_d  = '0;
                    mm_cnt_d   = '0;
                    ff_vec_d   = '0;
                    ff_valid_d = 1'b0;
                    settle_d   = SETTLE_LOAD;
                    state_d    = (num_q == '0) ? DONE : APPLY;
                end
                APPLY: begin
                    if (settle_q == '0) state_d = COMPARE;
                    else                settle_d = settle_q - SET_W'(1);
                end
                COMPARE: begin
                    vec_cnt_d = vec_cnt_q + CNT_W'(1);
                    if (golden_out_i != faulty_out_i) begin
                        err_d = 1'b1;
                        if (mm_cnt_q != '1) mm_cnt_d = mm_cnt_q + CNT_W'(1);
                        if (!ff_valid_q) begin
                            ff_vec_d   = lfsr_val;
                            ff_valid_d = 1'b1;
                        end
                    end
                    if (vec_cnt_d == num_q) begin
                        state_d = DONE;
                    end else begin
                        lfsr_step = 1'b1;
                        settle_d  = SETTLE_LOAD;
                        state_d   = APPLY;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            num_q      <= '0;
            seed_q     <= '0;
            vec_cnt_q  <= '0;
            mm_cnt_q   <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            num_q      <= num_d;
            seed_q     <= seed_d;
            vec_cnt_q  <= vec_cnt_d;
            mm_cnt_q   <= mm_cnt_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            err_q      <= err_d;
        end
    end

    assign dut_in_o           = lfsr_val;
    assign busy_o             = (state_q == LOAD) || (state_q == APPLY) || (state_q == COMPARE);
    assign done_o             = (state_q == DONE);
    assign vec_cnt_o          = vec_cnt_q;
    assign mismatch_cnt_o     = mm_cnt_q;
    assign err_pulse_o        = err_q;
    assign first_fail_vec_o   = ff_vec_q;
    assign first_fail_valid_o = ff_valid_q;
endmodule

// File: tb/tb_c432_campaign_sequencer.sv
// Self-checking bench: a schedule-based model of each campaign is compared against the
// sequencer every cycle, plus directed checks for reset, abort, held start and mid-run reset.
module tb_c432_campaign_sequencer;
    import c432_seq_pkg::*;

    localparam int S    = 2;
    localparam int MAXV = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [CNT_W-1:0] num_vectors_i = '0;
    logic [IN_W-1:0]  seed_i = '0;
    logic [IN_W-1:0]  dut_in_o;
    logic [OUT_W-1:0] golden_out_i, faulty_out_i;
    logic             busy_o, done_o, err_pulse_o, first_fail_valid_o;
    logic [CNT_W-1:0] vec_cnt_o, mismatch_cnt_o;
    logic [IN_W-1:0]  first_fail_vec_o;
    logic             fault_on = 1'b0;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc = 0;
    int done_seen = 0, busy_seen = 0, err_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    c432_campaign_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .abort_i            (abort_i),
        .num_vectors_i      (num_vectors_i),
        .seed_i             (seed_i),
        .dut_in_o           (dut_in_o),
        .golden_out_i       (golden_out_i),
        .faulty_out_i       (faulty_out_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .vec_cnt_o          (vec_cnt_o),
        .mismatch_cnt_o     (mismatch_cnt_o),
        .err_pulse_o        (err_pulse_o),
        .first_fail_vec_o   (first_fail_vec_o),
        .first_fail_valid_o (first_fail_valid_o)
    );

    // Stand-in for the golden c432; the faulty copy has N432 stuck at 1 when fault_on.
    function automatic logic [OUT_W-1:0] golden_fn(input logic [IN_W-1:0] x);
        return {^x[35:28], x[5:0] ^ x[29:24]};
    endfunction

    assign golden_out_i = golden_fn(dut_in_o);
    assign faulty_out_i = golden_out_i | (fault_on ? 7'h40 : 7'h00);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Campaign model: vector list, mismatch flags, prefix counts, and results before LOAD.
    logic [IN_W-1:0]  m_vec [MAXV];
    int               m_pre [MAXV+1];
    int               m_ffidx;
    int               m_n = 0, m_t0 = 0;
    bit               m_valid = 0, chk_en = 0;
    logic [IN_W-1:0]  p_dut = '0, p_ff = '0;
    logic [CNT_W-1:0] p_cnt = '0, p_mm = '0;
    logic             p_ffv = 1'b0;

    // Expected outputs t cycles after the cycle in which start was seen in IDLE.
    task automatic model_expect(input int t,
                                output logic [IN_W-1:0] e_dut, output logic e_busy,
                                output logic e_done, output logic e_err,
                                output logic [CNT_W-1:0] e_cnt, output logic [CNT_W-1:0] e_mm,
                                output logic [IN_W-1:0] e_ff, output logic e_ffv);
        int last, n_done, k, j;
        last   = m_n * (S + 1) + 2;
        e_busy = (t >= 1) && (t < last);
        e_done = (t == last);
        e_err  = 1'b0;
        if (t < 2) begin
            e_dut = p_dut; e_cnt = p_cnt; e_mm = p_mm; e_ff = p_ff; e_ffv = p_ffv;
        end else begin
            n_done = (t - 2) / (S + 1);
            if (n_done > m_n) n_done = m_n;
            k = (t - 2) / (S + 1);
            if (k > m_n - 1) k = m_n - 1;
            if (k < 0) k = 0;
            e_dut = m_vec[k];
            e_cnt = CNT_W'(n_done);
            e_mm  = CNT_W'(m_pre[n_done]);
            e_ffv = (m_ffidx >= 0) && (m_ffidx < n_done);
            e_ff  = e_ffv ? m_vec[m_ffidx] : '0;
            j = (t - 2) / (S + 1) - 1;
            if (t > 2 && (t - 2) % (S + 1) == 0 && j < m_n && j >= 0)
                e_err = (m_pre[j+1] != m_pre[j]);
        end
    endtask

    always @(negedge clk) begin
        if (done_o) done_seen++;
        if (busy_o) busy_seen++;
        if (err_pulse_o) err_seen++;
    end

    always @(negedge clk) begin
        logic [IN_W-1:0]  e_dut, e_ff;
        logic             e_busy, e_done, e_err, e_ffv;
        logic [CNT_W-1:0] e_cnt, e_mm;
        if (chk_en) begin
            model_expect(cyc - m_t0, e_dut, e_busy, e_done, e_err, e_cnt, e_mm, e_ff, e_ffv);
            chk("dut_in",     64'(dut_in_o),           64'(e_dut));
            chk("busy",       64'(busy_o),             64'(e_busy));
            chk("done",       64'(done_o),             64'(e_done));
            chk("err_pulse",  64'(err_pulse_o),        64'(e_err));
            chk("vec_cnt",    64'(vec_cnt_o),          64'(e_cnt));
            chk("mm_cnt",     64'(mismatch_cnt_o),     64'(e_mm));
            chk("ff_vec",     64'(first_fail_vec_o),   64'(e_ff));
            chk("ff_valid",   64'(first_fail_valid_o), 64'(e_ffv));
        end
    end

    // Called at negedge; returns one cycle later (t = 1, LOAD) plus 1 ns.
    task automatic start_campaign(input int n, input logic [IN_W-1:0] seed, input logic fault);
        logic [IN_W-1:0]  e_dut, e_ff;
        logic             e_busy, e_done, e_err, e_ffv;
        logic [CNT_W-1:0] e_cnt, e_mm;
        logic [OUT_W-1:0] g;
        @(negedge clk); #1;
        if (m_valid) begin
            model_expect(1 << 24, e_dut, e_busy, e_done, e_err, e_cnt, e_mm, e_ff, e_ffv);
            p_dut = e_dut; p_cnt = e_cnt; p_mm = e_mm; p_ff = e_ff; p_ffv = e_ffv;
        end
        m_vec[0] = (seed == '0) ? IN_W'(1) : seed;
        for (int k = 1; k < n; k++) m_vec[k] = lfsr_next(m_vec[k-1]);
        m_pre[0] = 0;
        m_ffidx  = -1;
        for (int k = 0; k < n; k++) begin
            g = golden_fn(m_vec[k]);
            m_pre[k+1] = m_pre[k] + ((fault && !g[6]) ? 1 : 0);
            if (m_ffidx < 0 && m_pre[k+1] != m_pre[k]) m_ffidx = k;
        end
        m_n = n; m_t0 = cyc; m_valid = 1; chk_en = 1;
        fault_on = fault; num_vectors_i = CNT_W'(n); seed_i = seed; start_i = 1'b1;
        done_seen = 0; busy_seen = 0; err_seen = 0;
        @(negedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic goto_t(input int base, input int tt);
        while (cyc - base < tt) @(negedge clk);
        #1;
    endtask

    initial begin
        int t0;
        // 1: reset, then idle
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dut_in",   64'(dut_in_o), 64'h0);
        chk("rst_busy",     64'(busy_o), 64'h0);
        chk("rst_done",     64'(done_o), 64'h0);
        chk("rst_vec_cnt",  64'(vec_cnt_o), 64'h0);
        chk("rst_mm_cnt",   64'(mismatch_cnt_o), 64'h0);
        chk("rst_err",      64'(err_pulse_o), 64'h0);
        chk("rst_ff_vec",   64'(first_fail_vec_o), 64'h0);
        chk("rst_ff_valid", 64'(first_fail_valid_o), 64'h0);
        rst_n = 1'b1;
        done_seen = 0; busy_seen = 0;
        repeat (20) @(negedge clk);
        #1;
        chk("idle_no_done", 64'(done_seen), 64'h0);
        chk("idle_no_busy", 64'(busy_seen), 64'h0);

        // 2: zero-length campaign
        start_campaign(0, 36'h5A5, 1'b0);
        goto_t(m_t0, 6);
        chk("n0_done_pulses", 64'(done_seen), 64'd1);
        chk("n0_busy_cycles", 64'(busy_seen), 64'd1);
        chk("n0_vec_cnt",     64'(vec_cnt_o), 64'd0);
        chk("n0_dut_in_seed", 64'(dut_in_o), 64'h5A5);

        // 3: 100 clean vectors from seed 1
        start_campaign(100, 36'h1, 1'b0);
        goto_t(m_t0, 8);
        chk("seed1_vec2", 64'(dut_in_o), 64'h4);
        goto_t(m_t0, 100 * (S + 1) + 2);
        chk("n100_done_at_302", 64'(done_o), 64'd1);
        goto_t(m_t0, 100 * (S + 1) + 5);
        chk("n100_vec_cnt", 64'(vec_cnt_o), 64'd100);
        chk("n100_mm_cnt",  64'(mismatch_cnt_o), 64'd0);
        chk("n100_done_pulses", 64'(done_seen), 64'd1);

        // 4: 1000 vectors, N432 stuck-at-1
        start_campaign(1000, 36'h9_1234_5678, 1'b1);
        goto_t(m_t0, 1000 * (S + 1) + 5);
        chk("sa1_mm_cnt",     64'(mismatch_cnt_o), 64'(m_pre[1000]));
        chk("sa1_err_pulses", 64'(err_seen), 64'(m_pre[1000]));
        chk("sa1_ff_valid",   64'(first_fail_valid_o), 64'(m_ffidx >= 0));
        chk("sa1_ff_vec",     64'(first_fail_vec_o), 64'(m_vec[m_ffidx < 0 ? 0 : m_ffidx]));
        chk("sa1_vec_cnt",    64'(vec_cnt_o), 64'd1000);

        // Tap pin: only bit 35 set steps to 1, then 2
        start_campaign(3, 36'h8_0000_0000, 1'b0);
        goto_t(m_t0, 2);
        chk("tap_vec0", 64'(dut_in_o), 64'h8_0000_0000);
        goto_t(m_t0, 5);
        chk("tap_vec1", 64'(dut_in_o), 64'h1);
        goto_t(m_t0, 8);
        chk("tap_vec2", 64'(dut_in_o), 64'h2);
        goto_t(m_t0, 14);

        // 5: zero seed, abort after 50 vectors
        start_campaign(200, 36'h0, 1'b1);
        goto_t(m_t0, 2);
        chk("seed0_vec0", 64'(dut_in_o), 64'h1);
        for (int i = 0; i < 400 && vec_cnt_o !== CNT_W'(50); i++) @(negedge clk);
        chk("abort_reach_50", 64'(vec_cnt_o), 64'd50);
        #1;
        chk_en = 0;
        abort_i = 1'b1;
        @(negedge clk); #1;
        abort_i = 1'b0;
        chk("abort_busy",    64'(busy_o), 64'h0);
        repeat (20) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(done_seen), 64'h0);
        chk("abort_vec_cnt", 64'(vec_cnt_o), 64'd50);
        chk("abort_mm_cnt",  64'(mismatch_cnt_o), 64'(m_pre[50]));
        chk("abort_idle",    64'(busy_o), 64'h0);

        // 6: start held through the campaign, then reset mid-campaign
        @(negedge clk); #1;
        t0 = cyc;
        fault_on = 1'b0; num_vectors_i = 32'd5; seed_i = 36'h3C; start_i = 1'b1;
        done_seen = 0;
        goto_t(t0, 16);
        chk("held_busy_16",   64'(busy_o), 64'd1);
        goto_t(t0, 17);
        chk("held_done_17",   64'(done_o), 64'd1);
        goto_t(t0, 18);
        chk("held_idle_18",   64'(busy_o), 64'd0);
        chk("held_done_once", 64'(done_seen), 64'd1);
        goto_t(t0, 19);
        chk("held_restart_19", 64'(busy_o), 64'd1);
        goto_t(t0, 25);
        chk("mid_vec_cnt", 64'(vec_cnt_o), 64'd1);
        start_i = 1'b0;
        rst_n = 1'b0;
        goto_t(t0, 26);
        chk("mrst_busy",    64'(busy_o), 64'h0);
        chk("mrst_dut_in",  64'(dut_in_o), 64'h0);
        chk("mrst_vec_cnt", 64'(vec_cnt_o), 64'h0);
        chk("mrst_ff",      64'({first_fail_valid_o, first_fail_vec_o, mismatch_cnt_o}), 64'h0);
        rst_n = 1'b1;
        goto_t(t0, 45);
        chk("mrst_no_done", 64'(done_seen), 64'd1);
        chk("mrst_idle",    64'(busy_o), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
